// File: rtl/dmem_port_arbiter.sv
// Data memory port arbiter: shares one single-ported memory between the
// pipeline MEM stage (core) and an external host loader/debug port.
// Core has priority; a host held off for STARVE_LIM contended cycles is
// given one forced grant. Read data is steered to whoever issued the read.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  // Core (MEM stage) side
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  // Host side
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  // Memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  // Last granted owner; also tells whose read is returning this cycle.
  typedef enum logic [1:0] {StIdle, StCore, StHost} state_t;

  state_t     state_q;
  logic [3:0] wait_cnt_q;
  logic       rd_pending_q;

  logic core_won;
  logic host_won;
  logic rd_host;

  // Winner selection: core first unless the host has waited long enough.
  always_comb begin
    core_won = 1'b0;
    host_won = 1'b0;
    if (!rst) begin
      if (core_req && (!host_req || (wait_cnt_q < StarveLim))) begin
        core_won = 1'b1;
      end else if (host_req) begin
        host_won = 1'b1;
      end
    end
  end

  // Memory port mux of the winner; everything zero when nobody is granted.
  always_comb begin
    mem_en    = core_won | host_won;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_won) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_won) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Requester-facing status and read-data steering.
  always_comb begin
    host_gnt    = host_won;
    core_stall  = core_req & ~core_won & ~rst;
    rd_host     = rd_pending_q & (state_q == StHost);
    // Gated by rst so a read granted just before reset never returns.
    host_rvalid = rd_host & ~rst;
    host_rdata  = host_rvalid ? mem_rdata : '0;
    core_rdata  = mem_rdata;
  end

  // Owner FSM, host starvation counter and read-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wait_cnt_q   <= 4'd0;
      rd_pending_q <= 1'b0;
    end else begin
      if (core_won) begin
        state_q <= StCore;
      end else if (host_won) begin
        state_q <= StHost;
      end else begin
        state_q <= StIdle;
      end

      if (!host_req || host_won) begin
        wait_cnt_q <= 4'd0;
      end else if (wait_cnt_q != 4'hF) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end

      rd_pending_q <= mem_en & ~mem_we;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized traffic checked against a behavioural arbitration/memory model.
module tb_dmem_port_arbiter;

  localparam int StarveLim = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [17:0] core_addr;
  logic [23:0] core_wdata;
  logic        core_stall;
  logic [23:0] core_rdata;
  logic        host_req, host_we;
  logic [17:0] host_addr;
  logic [23:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [23:0] host_rdata;
  logic        mem_en, mem_we;
  logic [17:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  // Memory fixture: synchronous single-port RAM.
  bit [23:0] fmem [0:262143];
  // Reference shadow of memory contents.
  bit [23:0] rmem [bit [17:0]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) fmem[mem_addr] <= mem_wdata;
      else mem_rdata <= fmem[mem_addr];
    end
  end

  dmem_port_arbiter #(
    .ADDR_W    (18),
    .DATA_W    (24),
    .STARVE_LIM(StarveLim)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_stall (core_stall),
    .core_rdata (core_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [23:0] ref_rd(bit [17:0] a);
    return rmem.exists(a) ? rmem[a] : 24'h0;
  endfunction

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; core_req = 1; host_req = 1; core_addr = 18'h5; host_addr = 18'h6;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset mem_en: got %b want 0", mem_en); end
      n_cmp++; if (host_gnt !== 1'b0) begin n_err++; $display("FAIL reset host_gnt: got %b want 0", host_gnt); end
      n_cmp++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL reset core_stall: got %b want 0", core_stall); end
      n_cmp++; if (mem_addr !== 18'h0) begin n_err++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
      n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL reset host_rvalid: got %b want 0", host_rvalid); end
      tick();
    end
    rst = 0;
    @(negedge clk);
    n_cmp++; if (host_gnt !== 1'b0) begin n_err++; $display("FAIL post_reset host_gnt: got %b want 0", host_gnt); end
    n_cmp++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL post_reset core_stall: got %b want 0", core_stall); end
    n_cmp++; if (mem_addr !== 18'h5) begin n_err++; $display("FAIL post_reset mem_addr: got %h want 00005", mem_addr); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_host_read();
    // Preload through the host port, then read it back.
    host_req = 1; host_we = 1; host_addr = 18'h00010; host_wdata = 24'hABCDEF;
    tick();
    host_we = 0; host_wdata = '0;
    @(negedge clk);
    n_cmp++; if (host_gnt !== 1'b1) begin n_err++; $display("FAIL host_read gnt: got %b want 1", host_gnt); end
    n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL host_read strobe: got en=%b we=%b want en=1 we=0", mem_en, mem_we); end
    tick();
    host_req = 0;
    @(negedge clk);
    n_cmp++; if (host_rvalid !== 1'b1) begin n_err++; $display("FAIL host_read rvalid: got %b want 1", host_rvalid); end
    n_cmp++; if (host_rdata !== 24'hABCDEF) begin n_err++; $display("FAIL host_read rdata: got %h want abcdef", host_rdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL host_read rvalid_drop: got %b want 0", host_rvalid); end
    n_cmp++; if (host_rdata !== 24'h0) begin n_err++; $display("FAIL host_read rdata_zero: got %h want 0", host_rdata); end
    tick();
  endtask

  task automatic test_contention();
    core_req = 1; core_addr = 18'h30; host_req = 1; host_addr = 18'h31;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++; if (host_gnt !== ((i % 4) == 3)) begin n_err++; $display("FAIL contention gnt[%0d]: got %b want %b", i, host_gnt, (i % 4) == 3); end
      n_cmp++; if (core_stall !== ((i % 4) == 3)) begin n_err++; $display("FAIL contention stall[%0d]: got %b want %b", i, core_stall, (i % 4) == 3); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_core_wr_rd();
    core_req = 1; core_we = 1; core_addr = 18'h00020; core_wdata = 24'h123456;
    @(negedge clk);
    n_cmp++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL core_wr stall: got %b want 0", core_stall); end
    n_cmp++; if (mem_we !== 1'b1 || mem_wdata !== 24'h123456) begin n_err++; $display("FAIL core_wr mem: got we=%b wdata=%h want we=1 wdata=123456", mem_we, mem_wdata); end
    tick();
    core_we = 0; core_wdata = '0;
    @(negedge clk);
    n_cmp++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL core_rd stall: got %b want 0", core_stall); end
    tick();
    core_req = 0;
    @(negedge clk);
    n_cmp++; if (core_rdata !== 24'h123456) begin n_err++; $display("FAIL core_rd rdata: got %h want 123456", core_rdata); end
    n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL core_rd host_rvalid: got %b want 0", host_rvalid); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    host_req = 1; host_we = 0; host_addr = 18'h00010;
    @(negedge clk);
    n_cmp++; if (host_gnt !== 1'b1) begin n_err++; $display("FAIL rst_mid gnt: got %b want 1", host_gnt); end
    tick();
    host_req = 0; rst = 1;
    @(negedge clk);
    n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid rvalid_in_rst: got %b want 0", host_rvalid); end
    n_cmp++; if (host_rdata !== 24'h0) begin n_err++; $display("FAIL rst_mid rdata_in_rst: got %h want 0", host_rdata); end
    tick();
    rst = 0;
    @(negedge clk);
    n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid rvalid_after: got %b want 0", host_rvalid); end
    tick();
    // Counter must restart from zero: three core wins before the host.
    core_req = 1; host_req = 1; host_addr = 18'h40; core_addr = 18'h41;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (host_gnt !== (i == 3)) begin n_err++; $display("FAIL rst_mid gnt_seq[%0d]: got %b want %b", i, host_gnt, i == 3); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_host_write_gap();
    host_req = 1; host_we = 1; host_addr = 18'h3FFFF; host_wdata = 24'h000FFF;
    @(negedge clk);
    n_cmp++; if (host_gnt !== 1'b1) begin n_err++; $display("FAIL host_wr gnt: got %b want 1", host_gnt); end
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL host_wr mem_we: got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 18'h3FFFF) begin n_err++; $display("FAIL host_wr mem_addr: got %h want 3ffff", mem_addr); end
    n_cmp++; if (mem_wdata !== 24'h000FFF) begin n_err++; $display("FAIL host_wr mem_wdata: got %h want 000fff", mem_wdata); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL host_wr rvalid: got %b want 0", host_rvalid); end
    tick();
  endtask

  task automatic test_random();
    int          prv_kind;   // 0 none, 1 core read, 2 host read
    logic [23:0] prv_data;
    int          ref_wait;
    bit          exp_h, exp_c;
    idle_inputs();
    tick();
    prv_kind = 0; prv_data = '0; ref_wait = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      core_req   = ($urandom_range(0, 9) < 6);
      core_we    = 1'($urandom_range(0, 1));
      core_addr  = 18'h100 + 18'($urandom_range(0, 15));
      core_wdata = 24'($urandom);
      if (!host_req) begin
        host_req   = ($urandom_range(0, 9) < 5);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 18'h100 + 18'($urandom_range(0, 15));
        host_wdata = 24'($urandom);
      end
      exp_h = host_req && (!core_req || ref_wait >= StarveLim);
      exp_c = core_req && !exp_h;
      @(negedge clk);
      n_cmp++; if (host_gnt !== exp_h) begin n_err++; $display("FAIL rand[%0d] host_gnt: got %b want %b", cyc, host_gnt, exp_h); end
      n_cmp++; if (core_stall !== (core_req && !exp_c)) begin n_err++; $display("FAIL rand[%0d] core_stall: got %b want %b", cyc, core_stall, core_req && !exp_c); end
      n_cmp++; if (mem_en !== (exp_h || exp_c)) begin n_err++; $display("FAIL rand[%0d] mem_en: got %b want %b", cyc, mem_en, exp_h || exp_c); end
      if (exp_c) begin
        n_cmp++; if (mem_addr !== core_addr || mem_we !== core_we) begin n_err++; $display("FAIL rand[%0d] core_mux: got a=%h we=%b want a=%h we=%b", cyc, mem_addr, mem_we, core_addr, core_we); end
      end else if (exp_h) begin
        n_cmp++; if (mem_addr !== host_addr || mem_we !== host_we) begin n_err++; $display("FAIL rand[%0d] host_mux: got a=%h we=%b want a=%h we=%b", cyc, mem_addr, mem_we, host_addr, host_we); end
      end else begin
        n_cmp++; if (mem_addr !== 18'h0 || mem_we !== 1'b0 || mem_wdata !== 24'h0) begin n_err++; $display("FAIL rand[%0d] idle_mux: got a=%h we=%b d=%h want zeros", cyc, mem_addr, mem_we, mem_wdata); end
      end
      n_cmp++; if (host_rvalid !== (prv_kind == 2)) begin n_err++; $display("FAIL rand[%0d] host_rvalid: got %b want %b", cyc, host_rvalid, prv_kind == 2); end
      n_cmp++; if (host_rdata !== ((prv_kind == 2) ? prv_data : 24'h0)) begin n_err++; $display("FAIL rand[%0d] host_rdata: got %h want %h", cyc, host_rdata, (prv_kind == 2) ? prv_data : 24'h0); end
      if (prv_kind == 1) begin
        n_cmp++; if (core_rdata !== prv_data) begin n_err++; $display("FAIL rand[%0d] core_rdata: got %h want %h", cyc, core_rdata, prv_data); end
      end
      prv_kind = 0;
      if (exp_c) begin
        if (core_we) rmem[core_addr] = core_wdata;
        else begin prv_kind = 1; prv_data = ref_rd(core_addr); end
      end else if (exp_h) begin
        if (host_we) rmem[host_addr] = host_wdata;
        else begin prv_kind = 2; prv_data = ref_rd(host_addr); end
      end
      if (host_req && !exp_h) ref_wait = (ref_wait < 15) ? ref_wait + 1 : 15;
      else ref_wait = 0;
      tick();
      if (exp_h) host_req = 0;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_host_read();
    test_contention();
    test_core_wr_rd();
    test_reset_mid_read();
    test_host_write_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
